secuenciador_clave: RTL and testbench

SECUENCIADOR_CLAVE -- requirements
Module: secuenciador_clave

---
 rtl/secuenciador_clave_pkg.sv | 15 +
 rtl/secuenciador_clave_timeout.sv | 30 +++
 rtl/secuenciador_clave.sv | 115 +++++++++++
 tb/tb_secuenciador_clave.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_clave_pkg.sv
// rtl/secuenciador_clave_pkg.sv - shared constants and one-hot state encoding for the keypad code sequencer
package secuenciador_clave_pkg;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam int         CLAVE_ANCHO = 16;

    typedef enum logic [4:0] {
        INACTIVO = 5'b00001,
        CAPTURA  = 5'b00010,
        COMPLETO = 5'b00100,
        ENVIO    = 5'b01000,
        ESPERA   = 5'b10000
    } estado_t;

endpackage

// File: rtl/secuenciador_clave_timeout.sv
// rtl/secuenciador_clave_timeout.sv - idle-cycle counter that flags when an entry has gone stale
module contador_timeout #(
    parameter int TIMEOUT = 1000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Habilitar,
    input  logic Reiniciar,
    output logic Expirado
);

    localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cuenta;

    // Count wraps to zero on expiry so a lingering enable cannot re-fire it next cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cuenta <= '0;
        end else if (Reiniciar || !Habilitar || (r_cuenta == ULTIMO)) begin
            r_cuenta <= '0;
        end else begin
            r_cuenta <= r_cuenta + CW'(1);
        end
    end

    assign Expirado = Habilitar && (r_cuenta == ULTIMO);

endmodule

// File: rtl/secuenciador_clave.sv
// rtl/secuenciador_clave.sv - collects four BCD keys, submits them with a timed Enter pulse
module secuenciador_clave
    import secuenciador_clave_pkg::*;
#(
    parameter int TIMEOUT      = 1000,
    parameter int ENTER_CICLOS = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Tecla,
    input  logic [3:0]             Digito,
    input  logic                   Borrar,
    input  logic                   Confirmar,
    output logic [CLAVE_ANCHO-1:0] Clave,
    output logic                   Enter,
    output logic [2:0]             NumDig,
    output logic                   Error
);

    localparam int               ECW      = (ENTER_CICLOS > 1) ? $clog2(ENTER_CICLOS) : 1;
    localparam logic [ECW-1:0]   ENTER_UL = ECW'(ENTER_CICLOS - 1);

    estado_t                r_estado;
    logic [CLAVE_ANCHO-1:0] r_clave;
    logic [2:0]             r_numdig;
    logic                   r_enter;
    logic                   r_error;
    logic [ECW-1:0]         r_cnt_enter;

    logic w_activo;
    logic w_conf;
    logic w_tec;
    logic w_acepta;
    logic w_expirado;

    // Borrar beats Confirmar beats Tecla; losers are simply dropped.
    assign w_conf   = Confirmar && !Borrar;
    assign w_tec    = Tecla && !Borrar && !Confirmar;
    assign w_activo = (r_estado == CAPTURA) || (r_estado == COMPLETO);
    assign w_acepta = w_tec && (Digito <= BCD_MAX)
                      && ((r_estado == INACTIVO) || (r_estado == CAPTURA));

    contador_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .Clk       (Clk),
        .Reset     (Reset),
        .Habilitar (w_activo),
        .Reiniciar (w_acepta),
        .Expirado  (w_expirado)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_estado    <= INACTIVO;
            r_clave     <= '0;
            r_numdig    <= 3'd0;
            r_enter     <= 1'b0;
            r_error     <= 1'b0;
            r_cnt_enter <= '0;
        end else begin
            r_error <= 1'b0;
            unique case (r_estado)
                INACTIVO, CAPTURA, COMPLETO: begin
                    if (Borrar) begin
                        r_clave  <= '0;
                        r_numdig <= 3'd0;
                        r_estado <= INACTIVO;
                    end else if (w_conf && (r_estado == COMPLETO)) begin
                        r_estado    <= ENVIO;
                        r_enter     <= 1'b1;
                        r_cnt_enter <= '0;
                    end else if (w_acepta) begin
                        r_clave  <= {r_clave[CLAVE_ANCHO-5:0], Digito};
                        r_numdig <= r_numdig + 3'd1;
                        r_estado <= (r_numdig == 3'd3) ? COMPLETO : CAPTURA;
                    end else if (w_expirado) begin
                        // A stale entry is discarded even if a rejected event arrives now; one Error covers both.
                        r_clave  <= '0;
                        r_numdig <= 3'd0;
                        r_estado <= INACTIVO;
                        r_error  <= 1'b1;
                    end else if (w_conf || w_tec) begin
                        r_error <= 1'b1;
                    end
                end
                ENVIO: begin
                    if (r_cnt_enter == ENTER_UL) begin
                        r_enter  <= 1'b0;
                        r_estado <= ESPERA;
                    end else begin
                        r_cnt_enter <= r_cnt_enter + ECW'(1);
                    end
                end
                ESPERA: begin
                    r_clave  <= '0;
                    r_numdig <= 3'd0;
                    r_estado <= INACTIVO;
                end
                default: begin
                    r_clave  <= '0;
                    r_numdig <= 3'd0;
                    r_enter  <= 1'b0;
                    r_estado <= INACTIVO;
                end
            endcase
        end
    end

    assign Clave  = r_clave;
    assign Enter  = r_enter;
    assign NumDig = r_numdig;
    assign Error  = r_error;

endmodule

// File: tb/tb_secuenciador_clave.sv
// tb/tb_secuenciador_clave.sv - bench for secuenciador_clave: vector table, corner sequences, random vs model
module tb_secuenciador_clave;

    localparam int TO = 12;
    localparam int EC = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Tecla = 1'b0;
    logic [3:0]  Digito = 4'd0;
    logic        Borrar = 1'b0;
    logic        Confirmar = 1'b0;
    logic [15:0] Clave;
    logic        Enter;
    logic [2:0]  NumDig;
    logic        Error;

    int n_cmp = 0;
    int n_bad = 0;

    secuenciador_clave #(.TIMEOUT(TO), .ENTER_CICLOS(EC)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Tecla     (Tecla),
        .Digito    (Digito),
        .Borrar    (Borrar),
        .Confirmar (Confirmar),
        .Clave     (Clave),
        .Enter     (Enter),
        .NumDig    (NumDig),
        .Error     (Error)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit        t;
        bit [3:0]  d;
        bit        b;
        bit        c;
        bit [15:0] clave;
        bit [2:0]  nd;
        bit        en;
        bit        er;
    } vec_t;

    vec_t tabla[$];

    // Reference model: list of held digits, edges since last accepted key, cycles left in submission
    int   m_dig[$];
    int   m_quiet;
    int   m_send;
    bit   m_enter;
    bit   m_err;

    function automatic vec_t v(bit t, bit [3:0] d, bit b, bit c,
                               bit [15:0] clave, bit [2:0] nd, bit en, bit er);
        vec_t r;
        r.t = t; r.d = d; r.b = b; r.c = c;
        r.clave = clave; r.nd = nd; r.en = en; r.er = er;
        return r;
    endfunction

    function automatic logic [15:0] m_clave();
        int acc;
        acc = 0;
        foreach (m_dig[i]) acc = acc * 16 + m_dig[i];
        return 16'(acc);
    endfunction

    task automatic model_reset();
        m_dig.delete();
        m_quiet = 0;
        m_send = 0;
        m_enter = 0;
        m_err = 0;
    endtask

    task automatic model_step(input bit t, input bit [3:0] d, input bit b, input bit c);
        m_err = 0;
        if (m_send > 0) begin
            m_send--;
            m_enter = (m_send > 1);
            if (m_send == 0) m_dig.delete();
        end else begin
            m_enter = 0;
            if (b) begin
                m_dig.delete();
            end else if (c && m_dig.size() == 4) begin
                m_send = EC + 1;
                m_enter = 1;
            end else if (t && !c && d <= 4'd9 && m_dig.size() < 4) begin
                m_dig.push_back(int'(d));
                m_quiet = 0;
            end else begin
                if (m_dig.size() > 0) m_quiet++;
                if (m_dig.size() > 0 && m_quiet >= TO) begin
                    m_dig.delete();
                    m_err = 1;
                end else if (c || t) begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input bit t, input bit [3:0] d, input bit b, input bit c);
        Tecla = t; Digito = d; Borrar = b; Confirmar = c;
        @(posedge Clk);
        model_step(t, d, b, c);
        #1;
        Tecla = 0; Digito = 4'd0; Borrar = 0; Confirmar = 0;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".clave"},  Clave,            m_clave());
        chk({nm, ".numdig"}, 16'(NumDig),      16'(m_dig.size()));
        chk({nm, ".enter"},  16'(Enter),       16'(m_enter));
        chk({nm, ".error"},  16'(Error),       16'(m_err));
    endtask

    task automatic chk_out(input string nm, input logic [15:0] clave, input logic [2:0] nd,
                           input logic en, input logic er);
        chk({nm, ".clave"},  Clave,       clave);
        chk({nm, ".numdig"}, 16'(NumDig), 16'(nd));
        chk({nm, ".enter"},  16'(Enter),  16'(en));
        chk({nm, ".error"},  16'(Error),  16'(er));
    endtask

    initial begin
        int  act;
        bit  rt, rb, rc;
        bit [3:0] rd;

        // keys 0,2,5,9 + Confirmar
        tabla.push_back(v(1, 4'd0, 0, 0, 16'h0000, 3'd1, 0, 0));
        tabla.push_back(v(1, 4'd2, 0, 0, 16'h0002, 3'd2, 0, 0));
        tabla.push_back(v(1, 4'd5, 0, 0, 16'h0025, 3'd3, 0, 0));
        tabla.push_back(v(1, 4'd9, 0, 0, 16'h0259, 3'd4, 0, 0));
        tabla.push_back(v(0, 4'd0, 0, 1, 16'h0259, 3'd4, 1, 0));
        tabla.push_back(v(0, 4'd0, 0, 0, 16'h0259, 3'd4, 1, 0));
        tabla.push_back(v(0, 4'd0, 0, 0, 16'h0259, 3'd4, 0, 0));
        tabla.push_back(v(0, 4'd0, 0, 0, 16'h0000, 3'd0, 0, 0));
        // keys 2,4 + early Confirmar, then still capturing
        tabla.push_back(v(1, 4'd2, 0, 0, 16'h0002, 3'd1, 0, 0));
        tabla.push_back(v(1, 4'd4, 0, 0, 16'h0024, 3'd2, 0, 0));
        tabla.push_back(v(0, 4'd0, 0, 1, 16'h0024, 3'd2, 0, 1));
        tabla.push_back(v(0, 4'd0, 0, 0, 16'h0024, 3'd2, 0, 0));
        tabla.push_back(v(1, 4'd6, 0, 0, 16'h0246, 3'd3, 0, 0));
        tabla.push_back(v(0, 4'd0, 1, 0, 16'h0000, 3'd0, 0, 0));
        // keys 1,A,3
        tabla.push_back(v(1, 4'd1,  0, 0, 16'h0001, 3'd1, 0, 0));
        tabla.push_back(v(1, 4'd10, 0, 0, 16'h0001, 3'd1, 0, 1));
        tabla.push_back(v(1, 4'd3,  0, 0, 16'h0013, 3'd2, 0, 0));
        tabla.push_back(v(0, 4'd0,  1, 0, 16'h0000, 3'd0, 0, 0));
        // keys 2,4,6,8, fifth key, Borrar+Confirmar together
        tabla.push_back(v(1, 4'd2, 0, 0, 16'h0002, 3'd1, 0, 0));
        tabla.push_back(v(1, 4'd4, 0, 0, 16'h0024, 3'd2, 0, 0));
        tabla.push_back(v(1, 4'd6, 0, 0, 16'h0246, 3'd3, 0, 0));
        tabla.push_back(v(1, 4'd8, 0, 0, 16'h2468, 3'd4, 0, 0));
        tabla.push_back(v(1, 4'd1, 0, 0, 16'h2468, 3'd4, 0, 1));
        tabla.push_back(v(0, 4'd0, 1, 1, 16'h0000, 3'd0, 0, 0));
        tabla.push_back(v(0, 4'd0, 0, 0, 16'h0000, 3'd0, 0, 0));
        tabla.push_back(v(0, 4'd0, 0, 0, 16'h0000, 3'd0, 0, 0));
        // priority: Confirmar over Tecla, Borrar over Tecla
        tabla.push_back(v(1, 4'd3, 0, 0, 16'h0003, 3'd1, 0, 0));
        tabla.push_back(v(1, 4'd5, 0, 1, 16'h0003, 3'd1, 0, 1));
        tabla.push_back(v(1, 4'd5, 1, 0, 16'h0000, 3'd0, 0, 0));

        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk_out("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        Reset = 1'b1;

        foreach (tabla[i]) begin
            apply(tabla[i].t, tabla[i].d, tabla[i].b, tabla[i].c);
            chk_out($sformatf("vec%0d", i), tabla[i].clave, tabla[i].nd, tabla[i].en, tabla[i].er);
        end

        // timeout: key 7 then TO idle cycles expires on the last one
        apply(1, 4'd7, 0, 0);
        for (int k = 0; k < TO - 1; k++) begin
            apply(0, 4'd0, 0, 0);
            chk_out($sformatf("to_idle%0d", k), 16'h0007, 3'd1, 1'b0, 1'b0);
        end
        apply(0, 4'd0, 0, 0);
        chk_out("to_expire", 16'h0000, 3'd0, 1'b0, 1'b1);
        apply(0, 4'd0, 0, 0);
        chk_out("to_after", 16'h0000, 3'd0, 1'b0, 1'b0);

        // a key on the expiry cycle wins and restarts the count
        apply(1, 4'd7, 0, 0);
        repeat (TO - 1) apply(0, 4'd0, 0, 0);
        apply(1, 4'd7, 0, 0);
        chk_out("to_keywin", 16'h0077, 3'd2, 1'b0, 1'b0);
        repeat (TO - 1) apply(0, 4'd0, 0, 0);
        chk_out("to_restart", 16'h0077, 3'd2, 1'b0, 1'b0);
        apply(0, 4'd0, 1, 0);

        // reset asserted during the first Enter cycle
        apply(1, 4'd1, 0, 0);
        apply(1, 4'd2, 0, 0);
        apply(1, 4'd3, 0, 0);
        apply(1, 4'd4, 0, 0);
        apply(0, 4'd0, 0, 1);
        chk_out("rst_pre", 16'h1234, 3'd4, 1'b1, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        chk_out("rst_async", 16'h0000, 3'd0, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        model_reset();
        for (int k = 0; k < EC + 2; k++) begin
            apply(0, 4'd0, 0, 0);
            chk_out($sformatf("rst_quiet%0d", k), 16'h0000, 3'd0, 1'b0, 1'b0);
        end
        apply(1, 4'd5, 0, 0);
        chk_out("rst_first", 16'h0005, 3'd1, 1'b0, 1'b0);
        apply(0, 4'd0, 1, 0);
        model_reset();

        // random traffic in segments of varying activity against the model
        for (int seg = 0; seg < 60; seg++) begin
            act = $urandom_range(0, 3);
            for (int k = 0; k < 40; k++) begin
                if (act == 0) rt = ($urandom_range(0, 99) < 4);
                else          rt = ($urandom_range(0, 99) < 15 * act + 10);
                rd = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
                rb = ($urandom_range(0, 99) < 3);
                rc = ($urandom_range(0, 99) < ((act == 0) ? 2 : 12));
                apply(rt, rd, rb, rc);
                chk_model($sformatf("rnd%0d_%0d", seg, k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
